dram_fpm: RTL and testbench

Parametrised cycle-sampled model of a multiplexed-address fast-page-mode DRAM with per-byte-lane CAS strobes, early and late (read-modify-write) write, CAS-before-RAS refresh with an internal row counter, and a refresh watchdog. It sits wherever board logic drives raw /RAS, /CAS and /WE from the video or CPU timing generator. It replaces the single-lane DRAM model for 16-bit CPU work RAM and for sprite and tile DRAM that uses page-mode bursts.

---
 rtl/dram_fpm.sv | 187 ++++++++++++++++++
 tb/tb_dram_fpm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_fpm.sv
// Cycle-sampled fast-page-mode DRAM model: byte-lane CAS, early/late write, CBR refresh, refresh watchdog.
// Latency: a read CAS fall sampled at edge k drives o_DOUT/o_DOUT_VALID at edge k; writes commit at edge k.
// Backpressure: none; strobes are sampled every cycle and every detected edge is acted on immediately.
module dram_fpm #(
    parameter int DW              = 16,
    parameter int LANES           = 2,
    parameter int RW              = 8,
    parameter int CW              = 8,
    parameter int REFRESH_TIMEOUT = 4096,
    parameter int INIT            = 0
) (
    input  logic             i_MCLK,
    input  logic             i_RST_n,
    input  logic [RW-1:0]    i_ADDR,
    input  logic [DW-1:0]    i_DIN,
    output logic [DW-1:0]    o_DOUT,
    output logic             o_DOUT_VALID,
    input  logic             i_RAS_n,
    input  logic [LANES-1:0] i_CAS_n,
    input  logic             i_WE_n,
    input  logic             i_OE_n,
    output logic             o_REFRESH_ERR,
    output logic [RW-1:0]    o_REF_ROW
);

    localparam int AW  = RW + CW;
    localparam int WDW = $clog2(REFRESH_TIMEOUT + 1);
    localparam logic [WDW-1:0] WDOG_MAX = WDW'(REFRESH_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROW_OPEN,
        S_CBR
    } state_t;

    state_t           state_q;
    logic             prev_ras;
    logic [LANES-1:0] prev_cas;
    logic             prev_we;
    // A strobe only produces a fall once it has been seen high since reset,
    // so a strobe held low across reset release does not fake an edge.
    logic             ras_arm;
    logic [LANES-1:0] cas_arm;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic [WDW-1:0]   wdog_q;
    logic [WDW-1:0]   wdog_nxt;

    logic             ras_fall;
    logic             ras_rise;
    logic [LANES-1:0] cas_fall;
    logic [LANES-1:0] cas_low;
    logic             any_cas_fall;
    logic             any_cas_low;
    logic             we_fall;

    logic [AW-1:0]    rd_idx;
    logic [DW-1:0]    rd_word;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [LANES-1:0] wr_be;

    assign ras_fall     = !i_RAS_n && prev_ras && ras_arm;
    assign ras_rise     = i_RAS_n && !prev_ras;
    assign cas_fall     = ~i_CAS_n & prev_cas & cas_arm;
    assign cas_low      = ~i_CAS_n;
    assign any_cas_fall = |cas_fall;
    assign any_cas_low  = |cas_low;
    assign we_fall      = !i_WE_n && prev_we;
    assign rd_idx       = {i_ADDR[CW-1:0], row_q};

    // Write-port decode: early write at a CAS fall, late write at a WE fall under held CAS.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = rd_idx;
        wr_be  = cas_low;
        if (i_RST_n && state_q == S_ROW_OPEN && !ras_rise) begin
            if (any_cas_fall) begin
                wr_en = !i_WE_n;
            end else if (we_fall && any_cas_low) begin
                wr_en  = 1'b1;
                wr_idx = {col_q, row_q};
            end
        end
    end

    // Watchdog next value: clear on any RAS fall, otherwise count up and saturate.
    always_comb begin
        if (ras_fall) begin
            wdog_nxt = '0;
        end else if (wdog_q == WDOG_MAX) begin
            wdog_nxt = wdog_q;
        end else begin
            wdog_nxt = wdog_q + 1'b1;
        end
    end

    if (INIT != 0) begin : g_mem
        logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};

        // Byte-lane masked array write; the array itself is never reset.
        always_ff @(posedge i_MCLK) begin
            if (wr_en) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wr_be[l]) mem[wr_idx][8*l +: 8] <= i_DIN[8*l +: 8];
                end
            end
        end
        assign rd_word = mem[rd_idx];
    end else begin : g_mem
        logic [DW-1:0] mem [0:(1<<AW)-1];

        // Byte-lane masked array write; the array itself is never reset.
        always_ff @(posedge i_MCLK) begin
            if (wr_en) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wr_be[l]) mem[wr_idx][8*l +: 8] <= i_DIN[8*l +: 8];
                end
            end
        end
        assign rd_word = mem[rd_idx];
    end

    // Strobe history, access FSM, refresh row counter and watchdog flag.
    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            state_q       <= S_IDLE;
            prev_ras      <= 1'b1;
            prev_cas      <= '1;
            prev_we       <= 1'b1;
            ras_arm       <= 1'b0;
            cas_arm       <= '0;
            row_q         <= '0;
            col_q         <= '0;
            wdog_q        <= '0;
            o_DOUT        <= '0;
            o_DOUT_VALID  <= 1'b0;
            o_REFRESH_ERR <= 1'b0;
            o_REF_ROW     <= '0;
        end else begin
            prev_ras <= i_RAS_n;
            prev_cas <= i_CAS_n;
            prev_we  <= i_WE_n;
            ras_arm  <= ras_arm | i_RAS_n;
            cas_arm  <= cas_arm | i_CAS_n;
            wdog_q   <= wdog_nxt;
            if (wdog_nxt == WDOG_MAX) o_REFRESH_ERR <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (ras_fall) begin
                        if (&i_CAS_n) begin
                            row_q   <= i_ADDR;
                            state_q <= S_ROW_OPEN;
                        end else begin
                            o_REF_ROW <= o_REF_ROW + 1'b1;
                            state_q   <= S_CBR;
                        end
                    end
                end
                S_ROW_OPEN: begin
                    if (ras_rise) begin
                        o_DOUT_VALID <= 1'b0;
                        state_q      <= S_IDLE;
                    end else if (any_cas_fall) begin
                        col_q <= i_ADDR[CW-1:0];
                        if (!i_WE_n) begin
                            o_DOUT_VALID <= 1'b0;
                        end else begin
                            o_DOUT       <= rd_word;
                            o_DOUT_VALID <= !i_OE_n;
                        end
                    end else if (we_fall && any_cas_low) begin
                        o_DOUT_VALID <= 1'b0;
                    end else if (!any_cas_low || i_OE_n) begin
                        o_DOUT_VALID <= 1'b0;
                    end
                end
                S_CBR: begin
                    if (ras_rise) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_fpm.sv
// Directed bench for dram_fpm: write/read, lane write, page mode, RMW, CBR, watchdog, reset.
// Inputs change and outputs are checked on the falling clock edge.
// Expected values are hand-computed constants.
module tb_dram_fpm;

    localparam int DW = 16;
    localparam int LANES = 2;
    localparam int RW = 8;
    localparam int CW = 8;

    logic             i_MCLK = 1'b0;
    logic             i_RST_n;
    logic [RW-1:0]    i_ADDR;
    logic [DW-1:0]    i_DIN;
    logic [DW-1:0]    o_DOUT;
    logic             o_DOUT_VALID;
    logic             i_RAS_n;
    logic [LANES-1:0] i_CAS_n;
    logic             i_WE_n;
    logic             i_OE_n;
    logic             o_REFRESH_ERR;
    logic [RW-1:0]    o_REF_ROW;

    int tests = 0;
    int fails = 0;

    dram_fpm #(
        .DW(DW), .LANES(LANES), .RW(RW), .CW(CW),
        .REFRESH_TIMEOUT(16), .INIT(0)
    ) dut (
        .i_MCLK(i_MCLK), .i_RST_n(i_RST_n), .i_ADDR(i_ADDR), .i_DIN(i_DIN),
        .o_DOUT(o_DOUT), .o_DOUT_VALID(o_DOUT_VALID), .i_RAS_n(i_RAS_n),
        .i_CAS_n(i_CAS_n), .i_WE_n(i_WE_n), .i_OE_n(i_OE_n),
        .o_REFRESH_ERR(o_REFRESH_ERR), .o_REF_ROW(o_REF_ROW)
    );

    always #5 i_MCLK = ~i_MCLK;

    task automatic step();
        @(negedge i_MCLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ras_open(input logic [RW-1:0] row);
        i_ADDR  = row;
        i_RAS_n = 1'b0;
        step();
    endtask

    task automatic ras_close();
        i_RAS_n = 1'b1;
        i_CAS_n = '1;
        i_WE_n  = 1'b1;
        step();
        step();
    endtask

    task automatic cas_write(input logic [CW-1:0] col, input logic [LANES-1:0] lanes,
                             input logic [DW-1:0] din);
        i_ADDR  = col;
        i_DIN   = din;
        i_WE_n  = 1'b0;
        i_CAS_n = ~lanes;
        step();
        i_CAS_n = '1;
        i_WE_n  = 1'b1;
        step();
    endtask

    task automatic cas_read(input string tag, input logic [CW-1:0] col, input logic [DW-1:0] exp);
        i_ADDR  = col;
        i_WE_n  = 1'b1;
        i_OE_n  = 1'b0;
        i_CAS_n = '0;
        step();
        check({tag, "_dout"}, 32'(o_DOUT), 32'(exp));
        check({tag, "_vld"}, 32'(o_DOUT_VALID), 32'd1);
        i_CAS_n = '1;
        step();
        check({tag, "_vld_drop"}, 32'(o_DOUT_VALID), 32'd0);
    endtask

    task automatic cbr_cycle();
        i_CAS_n = '0;
        step();
        i_RAS_n = 1'b0;
        step();
        i_RAS_n = 1'b1;
        step();
        i_CAS_n = '1;
        step();
    endtask

    initial begin
        i_RST_n = 1'b0;
        i_ADDR  = '0;
        i_DIN   = '0;
        i_RAS_n = 1'b1;
        i_CAS_n = '1;
        i_WE_n  = 1'b1;
        i_OE_n  = 1'b1;
        step(); step(); step();
        check("rst_dout", 32'(o_DOUT), 32'h0);
        check("rst_vld", 32'(o_DOUT_VALID), 32'd0);
        check("rst_err", 32'(o_REFRESH_ERR), 32'd0);
        check("rst_refrow", 32'(o_REF_ROW), 32'h0);

        // Watchdog: 16 idle edges after reset release trip the flag, 15 do not.
        i_RST_n = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("wdog_15", 32'(o_REFRESH_ERR), 32'd0);
        step();
        check("wdog_16", 32'(o_REFRESH_ERR), 32'd1);

        // Early write of both lanes, then read back.
        ras_open(8'h12);
        cas_write(8'h34, 2'b11, 16'hBEEF);
        ras_close();
        ras_open(8'h12);
        cas_read("wr_rd", 8'h34, 16'hBEEF);
        ras_close();

        // Lane 0 only write.
        ras_open(8'h12);
        cas_write(8'h34, 2'b01, 16'h1155);
        ras_close();
        ras_open(8'h12);
        cas_read("lane", 8'h34, 16'hBE55);
        ras_close();

        // Page mode: preload four columns in one RAS, then read them in one RAS.
        ras_open(8'h01);
        for (int c = 0; c < 4; c++) cas_write(8'(c), 2'b11, 16'hA000 + 16'(c));
        ras_close();
        ras_open(8'h01);
        cas_read("page0", 8'h00, 16'hA000);
        cas_read("page1", 8'h01, 16'hA001);
        cas_read("page2", 8'h02, 16'hA002);
        cas_read("page3", 8'h03, 16'hA003);
        ras_close();

        // Read-modify-write: read 0x0001, then WE falls under held CAS with 0x0002.
        ras_open(8'h05);
        cas_write(8'h07, 2'b11, 16'h0001);
        ras_close();
        ras_open(8'h05);
        i_ADDR  = 8'h07;
        i_WE_n  = 1'b1;
        i_OE_n  = 1'b0;
        i_CAS_n = '0;
        step();
        check("rmw_read", 32'(o_DOUT), 32'h0001);
        check("rmw_read_vld", 32'(o_DOUT_VALID), 32'd1);
        i_ADDR = 8'h00;
        i_DIN  = 16'h0002;
        i_WE_n = 1'b0;
        step();
        check("rmw_wr_vld", 32'(o_DOUT_VALID), 32'd0);
        ras_close();
        ras_open(8'h05);
        cas_read("rmw", 8'h07, 16'h0002);
        ras_close();

        // RAS rise and CAS fall on the same edge: no write.
        ras_open(8'h12);
        i_RAS_n = 1'b1;
        i_CAS_n = '0;
        i_ADDR  = 8'h34;
        i_DIN   = 16'hDEAD;
        i_WE_n  = 1'b0;
        step();
        ras_close();
        ras_open(8'h12);
        cas_read("ras_wins", 8'h34, 16'hBE55);
        ras_close();

        // 257 CBR refreshes: row counter wraps to 1, array untouched.
        cbr_cycle();
        check("cbr_first", 32'(o_REF_ROW), 32'h01);
        for (int i = 1; i < 257; i++) cbr_cycle();
        check("cbr_257", 32'(o_REF_ROW), 32'h01);
        ras_open(8'h12);
        cas_read("cbr_keep", 8'h34, 16'hBE55);
        ras_close();
        check("wdog_sticky", 32'(o_REFRESH_ERR), 32'd1);

        // Reset mid-ROW_OPEN with RAS and CAS held low.
        ras_open(8'h12);
        i_ADDR  = 8'h34;
        i_OE_n  = 1'b0;
        i_CAS_n = '0;
        step();
        check("pre_rst_vld", 32'(o_DOUT_VALID), 32'd1);
        i_RST_n = 1'b0;
        step(); step();
        check("mid_rst_dout", 32'(o_DOUT), 32'h0);
        check("mid_rst_vld", 32'(o_DOUT_VALID), 32'd0);
        check("mid_rst_err", 32'(o_REFRESH_ERR), 32'd0);
        check("mid_rst_refrow", 32'(o_REF_ROW), 32'h0);
        i_RST_n = 1'b1;
        step();
        i_CAS_n = '1;
        step();
        i_CAS_n = '0;
        i_WE_n  = 1'b1;
        step();
        check("post_rst_rd_vld", 32'(o_DOUT_VALID), 32'd0);
        check("post_rst_rd_dout", 32'(o_DOUT), 32'h0);
        i_CAS_n = '1;
        step();
        i_DIN   = 16'h7777;
        i_WE_n  = 1'b0;
        i_CAS_n = '0;
        step();
        check("post_rst_wr_vld", 32'(o_DOUT_VALID), 32'd0);
        ras_close();
        ras_open(8'h12);
        cas_read("post_rst_keep", 8'h34, 16'hBE55);
        ras_close();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
